// File: rtl/aes_pkg.sv
// AES-128 constants and round helper functions shared by the encryption core
// and its key-expansion step.
package aes_pkg;

    localparam int NR = 10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } aes_fsm_e;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Round index 1..10 maps onto RCON[0..9]; anything else yields zero.
    function automatic logic [7:0] get_rcon(input logic [3:0] r);
        if ((r >= 4'd1) && (r <= 4'd10)) begin
            return RCON[r - 4'd1];
        end else begin
            return 8'h00;
        end
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = SBOX[s[127-8*i -: 8]];
        end
        return o;
    endfunction

    // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
            o[103-32*c -: 8] = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion step: derives round key r from round key r-1.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] rkey_i,
    input  logic [3:0]   round_i,
    output logic [127:0] rkey_o
);

    logic [31:0] temp_s;
    logic [31:0] w0_s, w1_s, w2_s, w3_s;

    // Chained word XORs starting from the rotated, substituted last word.
    always_comb begin
        temp_s = sub_word(rot_word(rkey_i[31:0])) ^ {get_rcon(round_i), 24'h000000};
        w0_s   = rkey_i[127:96] ^ temp_s;
        w1_s   = rkey_i[95:64]  ^ w0_s;
        w2_s   = rkey_i[63:32]  ^ w1_s;
        w3_s   = rkey_i[31:0]   ^ w2_s;
        rkey_o = {w0_s, w1_s, w2_s, w3_s};
    end

endmodule

// File: rtl/aes_top.sv
// Iterative AES-128 encryption core: one round per clock, key expanded on the fly,
// round state exposed on cipher_text with a one-hot round indicator.
module aes_top
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic [127:0] plain_text,
    input  logic [127:0] cipher_key,
    output logic         done,
    output logic [9:0]   completed_round,
    output logic [127:0] cipher_text
);

    aes_fsm_e     fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rkey_q, rkey_d;
    logic [3:0]   round_q, round_d;
    logic         done_q, done_d;
    logic [9:0]   cround_q, cround_d;

    logic [127:0] rkey_next_s;
    logic [127:0] shifted_s;
    logic [127:0] round_out_s;

    aes_key_step u_key_step (
        .rkey_i  (rkey_q),
        .round_i (round_q),
        .rkey_o  (rkey_next_s)
    );

    // Round datapath; the final round bypasses MixColumns.
    always_comb begin
        shifted_s = shift_rows(sub_bytes(state_q));
        if (round_q == 4'(NR)) begin
            round_out_s = shifted_s ^ rkey_next_s;
        end else begin
            round_out_s = mix_columns(shifted_s) ^ rkey_next_s;
        end
    end

    // Next-state logic for the control FSM and the round registers.
    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        rkey_d   = rkey_q;
        round_d  = round_q;
        done_d   = 1'b0;
        cround_d = 10'd0;
        case (fsm_q)
            IDLE: begin
                if (start) begin
                    state_d  = plain_text ^ cipher_key;
                    rkey_d   = cipher_key;
                    round_d  = 4'd1;
                    cround_d = 10'd1;
                    fsm_d    = BUSY;
                end else begin
                    fsm_d    = IDLE;
                end
            end
            BUSY: begin
                state_d = round_out_s;
                rkey_d  = rkey_next_s;
                if (round_q == 4'(NR)) begin
                    done_d  = 1'b1;
                    round_d = 4'd0;
                    fsm_d   = IDLE;
                end else begin
                    cround_d = 10'd1 << round_q;
                    round_d  = round_q + 4'd1;
                end
            end
            default: begin
                fsm_d   = IDLE;
                round_d = 4'd0;
            end
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fsm_q    <= IDLE;
            state_q  <= 128'd0;
            rkey_q   <= 128'd0;
            round_q  <= 4'd0;
            done_q   <= 1'b0;
            cround_q <= 10'd0;
        end else begin
            fsm_q    <= fsm_d;
            state_q  <= state_d;
            rkey_q   <= rkey_d;
            round_q  <= round_d;
            done_q   <= done_d;
            cround_q <= cround_d;
        end
    end

    assign done            = done_q;
    assign completed_round = cround_q;
    assign cipher_text     = state_q;

endmodule

// File: tb/tb_aes_top.sv
// Directed FIPS-197 vectors against the iterative AES-128 core.
module tb_aes_top;

    logic         clk;
    logic         rstn;
    logic         start;
    logic [127:0] plain_text;
    logic [127:0] cipher_key;
    logic         done;
    logic [9:0]   completed_round;
    logic [127:0] cipher_text;

    int tests_run = 0;
    int tests_failed = 0;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] R1_B  = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes_top dut (
        .clk             (clk),
        .rstn            (rstn),
        .start           (start),
        .plain_text      (plain_text),
        .cipher_key      (cipher_key),
        .done            (done),
        .completed_round (completed_round),
        .cipher_text     (cipher_text)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Runs one block from the accepting edge through done.
    task automatic run_block(input logic [127:0] pt, input logic [127:0] key,
                             input logic [127:0] exp, input bit hold_start,
                             input bit toggle, input bit check_r1);
        int n;
        bit seen;
        plain_text = pt;
        cipher_key = key;
        start      = 1'b1;
        @(posedge clk); #1;
        n = 1;
        check_eq("accept_round", 128'(completed_round), 128'd1);
        check_eq("initial_ark", cipher_text, pt ^ key);
        check_eq("accept_no_done", 128'(done), 128'd0);
        if (!hold_start) start = 1'b0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            if (toggle) begin
                plain_text = ~plain_text;
                cipher_key = {cipher_key[0], cipher_key[127:1]};
                start      = ~start;
            end
            @(posedge clk); #1;
            n++;
            if (check_r1 && n == 2) check_eq("round1_state", cipher_text, R1_B);
            if (done) seen = 1'b1;
            else check_eq("round_onehot", 128'(completed_round), 128'(10'd1 << (n - 1)));
        end
        check_eq("done_seen", 128'(seen), 128'd1);
        check_eq("latency", 128'(n), 128'd11);
        check_eq("ciphertext", cipher_text, exp);
        check_eq("done_round_zero", 128'(completed_round), 128'd0);
    endtask

    // Idle for a few cycles with start low: done stays low, ciphertext holds.
    task automatic check_idle(input logic [127:0] exp);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("idle_no_done", 128'(done), 128'd0);
            check_eq("idle_round_zero", 128'(completed_round), 128'd0);
            check_eq("idle_hold", cipher_text, exp);
        end
    endtask

    initial begin
        rstn       = 1'b0;
        start      = 1'b0;
        plain_text = 128'd0;
        cipher_key = 128'd0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_done", 128'(done), 128'd0);
        check_eq("reset_round", 128'(completed_round), 128'd0);
        check_eq("reset_ct", cipher_text, 128'd0);
        rstn = 1'b1;
        @(posedge clk); #1;
        check_eq("idle_after_reset", 128'(completed_round), 128'd0);

        // FIPS-197 Appendix B with round-1 state check.
        run_block(PT_B, KEY_B, CT_B, 1'b0, 1'b0, 1'b1);
        check_idle(CT_B);

        // Appendix C.1 then the all-zero vector, start held high throughout.
        run_block(PT_C, KEY_C, CT_C, 1'b1, 1'b0, 1'b0);
        run_block(128'd0, 128'd0, CT_Z, 1'b0, 1'b0, 1'b0);
        check_idle(CT_Z);

        // Inputs and start toggling while busy must not disturb the result.
        run_block(PT_C, KEY_C, CT_C, 1'b0, 1'b1, 1'b0);
        check_idle(CT_C);

        // Abort mid-round with reset, then rerun Appendix B.
        plain_text = PT_B;
        cipher_key = KEY_B;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_eq("mid_round_busy", 128'(completed_round), 128'(10'd1 << 5));
        rstn = 1'b0;
        #1;
        check_eq("abort_done", 128'(done), 128'd0);
        check_eq("abort_round", 128'(completed_round), 128'd0);
        check_eq("abort_ct", cipher_text, 128'd0);
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check_eq("post_abort_no_done", 128'(done), 128'd0);
        end
        run_block(PT_B, KEY_B, CT_B, 1'b0, 1'b0, 1'b1);
        check_idle(CT_B);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/aes_top.md
Name: aes_top

Overview:
- Iterative AES-128 encryption core: one 128-bit block and one 128-bit key in, ciphertext out.
- Computes one round per clock with on-the-fly key expansion.
- Exposes the intermediate state and a one-hot round indicator for per-round checking.
- Top-level encryption engine; driven by a simple start/done handshake.

Parameters:
- None. AES-128 only: Nk=4, Nr=10, fixed.

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous active-low reset
- start  input  1  request to encrypt; level-sensitive, sampled only when idle
- plain_text  input  128  plaintext block; [127:120] is FIPS-197 byte 0; column-major state
- cipher_key  input  128  cipher key, same byte ordering
- done  output  1  one-cycle pulse; cipher_text holds the final ciphertext
- completed_round  output  10  one-hot; bit0 = initial AddRoundKey done, bit k = round k done (k=1..9); zero otherwise
- cipher_text  output  128  registered state: intermediate round state while busy, final ciphertext at and after done

Behaviour:
- Reset (rstn=0, async): state, round key, round counter and cipher_text cleared to 0; done=0; completed_round=0; FSM to IDLE.
- FSM states: IDLE, BUSY.
- IDLE + start=1 at a rising edge:
  - Capture plain_text and cipher_key.
  - state <= plain_text ^ cipher_key.
  - round key <= cipher_key.
  - completed_round <= 10'b0000000001; go to BUSY with round counter = 1.
- IDLE + start=0: outputs hold, completed_round=0, done=0.
- BUSY, counter r=1..9:
  - Each edge applies SubBytes, ShiftRows, MixColumns, AddRoundKey(RK_r).
  - RK_r is derived from RK_(r-1) in the same cycle using Rcon[r].
  - completed_round <= 1<<r.
- BUSY, r=10:
  - Final round without MixColumns.
  - done <= 1 for exactly one cycle; completed_round <= 0; return to IDLE.
- Latency: done is high 11 clocks after the accepting edge.
- Back-to-back: if start is still 1 on the edge after done, a new block is accepted immediately (throughput 11 cycles/block). Inputs may change on the falling edge while done=1.
- start during BUSY is ignored.
- Inputs are sampled only on the accepting edge; changes during BUSY have no effect.
- cipher_text holds the last ciphertext in IDLE until the next accept overwrites it.
- Reset mid-operation aborts the block: no done, all outputs zero.
- Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- MixColumns uses xtime over GF(2^8) with polynomial 0x11b.

Decomposition:
- Package aes_pkg:
  - S-box constant array (256 x 8).
  - Rcon array.
  - Functions: xtime, sub_word, rot_word, shift_rows, mix_columns.
  - Nr=10 localparam.
- One sub-module aes_key_step:
  - Inputs: 128-bit round key and round index.
  - Output: next round key.
  - Uses 4 S-box lookups.
- The state datapath (16 S-box lookups) stays in aes_top.

Test Plan:
- FIPS-197 App B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, start=1.
  - Cycle 1: completed_round=001h, cipher_text=193de3bea0f4e22b9ac68d2ae9f84808.
  - Next cycle: completed_round=002h, cipher_text=a49c7ff2689f352b6b5bea43026a5049.
  - done after 11 cycles: cipher_text=3925841d02dc09fbdc118597196a0b32.
- FIPS-197 App C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
- start held high, 1000 random vectors applied on each done pulse -> each done is 11 cycles apart; all outputs match a software AES-128 model; completed_round walks 001h..200h each block.
- Toggle plain_text/cipher_key/start during BUSY -> result unchanged; no extra done.
- Deassert rstn mid-round (e.g. round 5) -> all outputs 0 immediately; after release plus start, the App B vector completes correctly.
- Zero vector: key 0, pt 0 -> 66e94bd4ef8a2c3b884cfa59ca342b2e.
